// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Writeback arbiter that sits directly after the functional units. Each
//   unit raises done with its result and holds it until accepted. At dispatch
//   the destination register of every instruction is queued per unit in
//   issue order. Each cycle at most one eligible unit is granted, using
//   round-robin priority. The granted unit's head tag is paired with its
//   result and sent to a registered register-file write port.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   issue_valid_i         dispatch of an instruction that writes back
//   issue_unit_i          unit index of the dispatched instruction
//   issue_rd_addr_i       destination register of the dispatched instruction
//   unit_done_i           per-unit result valid, held until accepted
//   unit_rd_i             per-unit result; unit i at [i*XLEN +: XLEN]
//   unit_accepted_o       one-hot or zero; head result consumed this cycle
//   tag_full_o            per-unit tag queue full, so decode must stall
//   rf_we_o/waddr_o/wdata_o  registered register-file write port
//   tag_error_o           sticky per-unit protocol error
//
// NUM_UNITS and TAG_FIFO_DEPTH must each be a power of two that is >= 2.
// The read and write pointers then wrap naturally.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int NUM_UNITS      = 4,
  parameter int XLEN           = 32,
  parameter int TAG_FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  input  logic [$clog2(NUM_UNITS)-1:0] issue_unit_i,
  input  logic [4:0]                   issue_rd_addr_i,
  input  logic [NUM_UNITS-1:0]         unit_done_i,
  input  logic [NUM_UNITS*XLEN-1:0]    unit_rd_i,
  output logic [NUM_UNITS-1:0]         unit_accepted_o,
  output logic [NUM_UNITS-1:0]         tag_full_o,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [XLEN-1:0]              rf_wdata_o,
  output logic [NUM_UNITS-1:0]         tag_error_o
);

  localparam int UW = $clog2(NUM_UNITS);
  localparam int PW = $clog2(TAG_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      tag_mem_q [NUM_UNITS][TAG_FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q  [NUM_UNITS];
  logic [PW-1:0]   wr_ptr_q  [NUM_UNITS];
  logic [CW-1:0]   count_q   [NUM_UNITS];

  logic [UW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
  logic [NUM_UNITS-1:0] tag_error_q, tag_error_d;

  logic [NUM_UNITS-1:0] full, eligible, push_sel, push_ok, grant_onehot;
  logic                 grant_valid;
  logic [UW-1:0]        grant_idx, cand_idx;
  logic [4:0]           head_tag;
  logic [XLEN-1:0]      head_data;

  // Per-unit status. A unit may only be granted when its tag queue holds
  // the matching destination. A push into a full queue is kept only when
  // the same queue pops in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      full[i]     = (count_q[i] == CW'(TAG_FIFO_DEPTH));
      eligible[i] = unit_done_i[i] && (count_q[i] != '0);
      push_sel[i] = issue_valid_i && (issue_unit_i == UW'(i));
      push_ok[i]  = push_sel[i] && (!full[i] || grant_onehot[i]);
    end
  end

  // Round-robin search. It starts at the pointer and wraps upward, and the
  // first eligible unit wins. Reset suppresses every grant.
  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    cand_idx     = '0;
    grant_onehot = '0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      cand_idx = rr_ptr_q + UW'(off);
      if (!grant_valid && eligible[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (rst_i) begin
      grant_valid = 1'b0;
    end
    if (grant_valid) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  assign head_tag  = tag_mem_q[grant_idx][rd_ptr_q[grant_idx]];
  assign head_data = unit_rd_i[int'(grant_idx)*XLEN +: XLEN];

  // Next state for the pointer, the write port and the errors. An x0
  // destination is consumed but never written. With no grant, the
  // address and data hold their values.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_valid) begin
      rr_ptr_d   = grant_idx + UW'(1);
      rf_we_d    = (head_tag != 5'd0);
      rf_waddr_d = head_tag;
      rf_wdata_d = head_data;
    end
    tag_error_d = tag_error_q
                | (unit_done_i & ~eligible)
                | (push_sel & full & ~grant_onehot);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      tag_error_q <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (push_ok[i]) begin
          tag_mem_q[i][wr_ptr_q[i]] <= issue_rd_addr_i;
          wr_ptr_q[i]               <= wr_ptr_q[i] + PW'(1);
        end
        if (grant_onehot[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        end
        if (push_ok[i] && !grant_onehot[i]) begin
          count_q[i] <= count_q[i] + CW'(1);
        end else if (grant_onehot[i] && !push_ok[i]) begin
          count_q[i] <= count_q[i] - CW'(1);
        end
      end
      rr_ptr_q    <= rr_ptr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      tag_error_q <= tag_error_d;
    end
  end

  assign unit_accepted_o = grant_onehot;
  assign tag_full_o      = full;
  assign rf_we_o         = rf_we_q;
  assign rf_waddr_o      = rf_waddr_q;
  assign rf_wdata_o      = rf_wdata_q;
  assign tag_error_o     = tag_error_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed bench for wb_arbiter. A queue-based model of the writeback
//   rules is compared with the DUT on every falling edge. Hand-computed
//   literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int N     = 4;
  localparam int XL    = 32;
  localparam int DEPTH = 4;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            iv    = 1'b0;
  logic [1:0]      iu    = '0;
  logic [4:0]      ird   = '0;
  logic [N-1:0]    done  = '0;
  logic [N*XL-1:0] unitRd;

  logic [N-1:0]  unitAccepted;
  logic [N-1:0]  tagFull;
  logic          rfWe;
  logic [4:0]    rfWaddr;
  logic [XL-1:0] rfWdata;
  logic [N-1:0]  tagError;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Model state: plain queues of destinations plus the expected write port.
  logic [4:0]    mQ [N][$];
  int            mPtr   = 0;
  logic [N-1:0]  mErr   = '0;
  logic          mWe    = 1'b0;
  logic [4:0]    mWaddr = '0;
  logic [XL-1:0] mWdata = '0;
  int            k, c;
  logic [N-1:0]  expAcc, expFull;
  logic [4:0]    tag;

  wb_arbiter #(.NUM_UNITS(N), .XLEN(XL), .TAG_FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .issue_valid_i   (iv),
    .issue_unit_i    (iu),
    .issue_rd_addr_i (ird),
    .unit_done_i     (done),
    .unit_rd_i       (unitRd),
    .unit_accepted_o (unitAccepted),
    .tag_full_o      (tagFull),
    .rf_we_o         (rfWe),
    .rf_waddr_o      (rfWaddr),
    .rf_wdata_o      (rfWdata),
    .tag_error_o     (tagError)
  );

  always #5 clk = ~clk;

  // Each unit presents a fixed, distinct result.
  initial begin
    unitRd[0*XL +: XL] = 32'hA000_0000;
    unitRd[1*XL +: XL] = 32'hDEAD_BEEF;
    unitRd[2*XL +: XL] = 32'hC2C2_C2C2;
    unitRd[3*XL +: XL] = 32'h3333_3333;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then return at
  // the falling edge so the caller can sample outputs.
  task automatic applyStimulus(input logic v, input logic [1:0] u, input logic [4:0] r,
                               input logic [N-1:0] d, input logic rs);
    @(posedge clk);
    #1;
    iv   = v;
    iu   = u;
    ird  = r;
    done = d;
    rst  = rs;
    @(negedge clk);
  endtask

  // Model compare. First the registered outputs are checked against the
  // model's write port, and the grant against a fresh round-robin search
  // over the queues. Then the model advances to the state after the next
  // rising edge.
  always @(negedge clk) begin
    if (checkEn) begin
      k = -1;
      if (!rst) begin
        for (int off = 0; off < N; off++) begin
          c = (mPtr + off) % N;
          if (k < 0 && done[c[1:0]] && mQ[c].size() > 0) k = c;
        end
      end
      expAcc = '0;
      if (k >= 0) expAcc[k[1:0]] = 1'b1;
      for (int u = 0; u < N; u++) expFull[u] = (mQ[u].size() == DEPTH);

      checkOutput("model_accept",   32'(unitAccepted), 32'(expAcc));
      checkOutput("model_full",     32'(tagFull),      32'(expFull));
      checkOutput("model_error",    32'(tagError),     32'(mErr));
      checkOutput("model_rf_we",    32'(rfWe),         32'(mWe));
      checkOutput("model_rf_waddr", 32'(rfWaddr),      32'(mWaddr));
      checkOutput("model_rf_wdata", rfWdata,           mWdata);

      if (rst) begin
        for (int u = 0; u < N; u++) mQ[u].delete();
        mPtr   = 0;
        mErr   = '0;
        mWe    = 1'b0;
        mWaddr = '0;
        mWdata = '0;
      end else begin
        for (int u = 0; u < N; u++)
          if (done[u] && mQ[u].size() == 0) mErr[u] = 1'b1;
        if (k >= 0) begin
          tag    = mQ[k].pop_front();
          mWe    = (tag != 5'd0);
          mWaddr = tag;
          mWdata = unitRd[k*XL +: XL];
          mPtr   = (k + 1) % N;
        end else begin
          mWe = 1'b0;
        end
        if (iv) begin
          if (mQ[iu].size() < DEPTH) mQ[iu].push_back(ird);
          else mErr[iu] = 1'b1;
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_we",     32'(rfWe),         32'd0);
    checkOutput("reset_accept", 32'(unitAccepted), 32'd0);
    checkOutput("reset_full",   32'(tagFull),      32'd0);
    checkOutput("reset_error",  32'(tagError),     32'd0);
    checkOutput("reset_waddr",  32'(rfWaddr),      32'd0);
    checkOutput("reset_wdata",  rfWdata,           32'd0);

    // Single writeback: rd=5 on unit 1, done three cycles after issue.
    applyStimulus(1'b1, 2'd1, 5'd5, 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0010, 1'b0);
    checkOutput("single_accept", 32'(unitAccepted), 32'h2);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("single_we",    32'(rfWe),    32'd1);
    checkOutput("single_waddr", 32'(rfWaddr), 32'd5);
    checkOutput("single_wdata", rfWdata,      32'hDEAD_BEEF);

    // Full contention from pointer 0. The done bits drop as each unit is
    // accepted.
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b1);
    for (int u = 0; u < N; u++) applyStimulus(1'b1, 2'(u), 5'(u + 1), 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b1111, 1'b0);
    checkOutput("rr_accept0", 32'(unitAccepted), 32'h1);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b1110, 1'b0);
    checkOutput("rr_accept1", 32'(unitAccepted), 32'h2);
    checkOutput("rr_waddr1",  32'(rfWaddr),      32'd1);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b1100, 1'b0);
    checkOutput("rr_accept2", 32'(unitAccepted), 32'h4);
    checkOutput("rr_waddr2",  32'(rfWaddr),      32'd2);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b1000, 1'b0);
    checkOutput("rr_accept3", 32'(unitAccepted), 32'h8);
    checkOutput("rr_waddr3",  32'(rfWaddr),      32'd3);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("rr_waddr4", 32'(rfWaddr), 32'd4);
    checkOutput("rr_we4",    32'(rfWe),    32'd1);
    checkOutput("rr_wdata4", rfWdata,      32'h3333_3333);

    // An x0 destination is consumed without a register-file write.
    applyStimulus(1'b1, 2'd2, 5'd0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0100, 1'b0);
    checkOutput("x0_accept", 32'(unitAccepted), 32'h4);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("x0_we", 32'(rfWe), 32'd0);

    // Fill queue 0, overflow it, then push and pop together while full.
    for (int r = 10; r < 14; r++) applyStimulus(1'b1, 2'd0, 5'(r), 4'b0000, 1'b0);
    applyStimulus(1'b1, 2'd0, 5'd14, 4'b0000, 1'b0);
    checkOutput("full_set",       32'(tagFull),  32'h1);
    checkOutput("full_err_clear", 32'(tagError), 32'h0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("overflow_err", 32'(tagError), 32'h1);
    applyStimulus(1'b1, 2'd0, 5'd15, 4'b0001, 1'b0);
    checkOutput("full_pushpop_accept", 32'(unitAccepted), 32'h1);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("full_pushpop_full",  32'(tagFull),  32'h1);
    checkOutput("full_pushpop_err",   32'(tagError), 32'h1);
    checkOutput("full_pushpop_waddr", 32'(rfWaddr),  32'd10);
    for (int j = 0; j < DEPTH; j++) applyStimulus(1'b0, 2'd0, 5'd0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("drain_last_waddr", 32'(rfWaddr), 32'd15);
    checkOutput("drain_full_clear", 32'(tagFull), 32'h0);

    // Done raised with an empty queue.
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b1000, 1'b0);
    checkOutput("empty_done_accept", 32'(unitAccepted), 32'h0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("empty_done_err", 32'(tagError), 32'h9);
    checkOutput("empty_done_we",  32'(rfWe),     32'd0);

    // Reset while tags are queued and unit 1 is done.
    applyStimulus(1'b1, 2'd1, 5'd20, 4'b0000, 1'b0);
    applyStimulus(1'b1, 2'd1, 5'd21, 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0010, 1'b1);
    checkOutput("rst_accept", 32'(unitAccepted), 32'h0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("rst_we",   32'(rfWe),     32'd0);
    checkOutput("rst_err",  32'(tagError), 32'h0);
    checkOutput("rst_full", 32'(tagFull),  32'h0);
    // Without the reset, the pointer would sit at 1 and unit 3 would win.
    applyStimulus(1'b1, 2'd0, 5'd7, 4'b0000, 1'b0);
    applyStimulus(1'b1, 2'd3, 5'd8, 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b1001, 1'b0);
    checkOutput("rst_ptr_accept", 32'(unitAccepted), 32'h1);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b1000, 1'b0);
    checkOutput("rst_ptr_accept3", 32'(unitAccepted), 32'h8);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("rst_ptr_waddr", 32'(rfWaddr), 32'd8);
    // Unit 1's tags were flushed, so its done now counts as an error.
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0010, 1'b0);
    checkOutput("flushed_accept", 32'(unitAccepted), 32'h0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("flushed_err", 32'(tagError), 32'h2);

    // Sustained contention between units 1 and 2 alternates the grants.
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 2'(1 + (j % 2)), 5'(22 + j), 4'b0000, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0110, 1'b0);
    checkOutput("alt_accept0", 32'(unitAccepted), 32'h2);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0110, 1'b0);
    checkOutput("alt_accept1", 32'(unitAccepted), 32'h4);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0110, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0110, 1'b0);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);
    checkOutput("alt_last_waddr", 32'(rfWaddr), 32'd25);
    applyStimulus(1'b0, 2'd0, 5'd0, 4'b0000, 1'b0);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
